miriscv_int_controller: RTL and testbench

- Interrupt controller between the external request lines and the miriscv core.
- Masks the incoming level requests with the core's mie CSR and picks one winner (fixed or round-robin priority).
- Presents the winner to the core as a single interrupt with an mcause value, tracks it through trap entry and mret, then pulses the matching int_fin_o bit so the requester drops its line.

---
 rtl/miriscv_int_controller.sv | 118 +++++++++++
 tb/tb_miriscv_int_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_int_controller.sv
// Interrupt controller for the miriscv core.
// Masks level requests with mie, arbitrates one winner (fixed or round-robin),
// presents it as int_o/mcause_o, follows it through trap entry (int_ack_i) and
// mret (int_rst_i), then pulses the matching int_fin_o bit for one cycle.
module miriscv_int_controller #(
  parameter int          N_IRQ       = 32,
  parameter int          ARB_MODE    = 0,
  parameter logic [31:0] MCAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_ack_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_fin_o,
  output logic             busy_o
);

  localparam int ID_W = $clog2(N_IRQ);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [ID_W-1:0]  id_q,     id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]      mcause_q, mcause_d;
  logic             int_q;
  logic [N_IRQ-1:0] fin_q,    fin_d;

  logic [N_IRQ-1:0] pend;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  int               idx;

  assign pend = int_req_i & mie_i;

  // Pick the winning pending line: lowest index, or first at/after rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ARB_MODE == 0) begin
        idx = i;
      end else begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_IRQ) idx = idx - N_IRQ;
      end
      if (!win_found && pend[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // Next-state logic for the interrupt life cycle and the latched id/mcause/rr_ptr.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    mcause_d = mcause_q;
    rr_ptr_d = rr_ptr_q;
    fin_d    = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = PENDING;
          id_d     = win_id;
          mcause_d = MCAUSE_BASE + 32'(win_id);
        end
      end
      PENDING: begin
        // Ack takes precedence over a same-cycle withdrawal of the line.
        if (int_ack_i)       state_d = SERVICE;
        else if (!pend[id_q]) state_d = IDLE;
      end
      SERVICE: begin
        if (int_rst_i) state_d = FINISH;
      end
      default: begin
        state_d  = IDLE;
        rr_ptr_d = (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + ID_W'(1);
      end
    endcase
    // Completion pulse is registered so it is high exactly while in FINISH.
    if (state_d == FINISH) fin_d[id_q] = 1'b1;
  end

  // State and registered outputs; reset aborts everything including a pending fin pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= '0;
      rr_ptr_q <= '0;
      mcause_q <= MCAUSE_BASE;
      int_q    <= 1'b0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      mcause_q <= mcause_d;
      int_q    <= (state_d == PENDING);
      fin_q    <= fin_d;
    end
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_miriscv_int_controller.sv
// Directed bench for miriscv_int_controller: one fixed-priority and one
// round-robin instance driven from shared inputs.
module tb_miriscv_int_controller;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [31:0] mie;
  logic        ack;
  logic        irst;

  logic        f_int,  r_int;
  logic [31:0] f_mc,   r_mc;
  logic [31:0] f_fin,  r_fin;
  logic        f_busy, r_busy;

  int n_cmp;
  int n_fail;

  miriscv_int_controller #(.N_IRQ(32), .ARB_MODE(0), .MCAUSE_BASE(32'h8000_0010)) u_fix (
    .clk_i(clk), .rst_i(rst), .int_req_i(req), .mie_i(mie),
    .int_ack_i(ack), .int_rst_i(irst),
    .int_o(f_int), .mcause_o(f_mc), .int_fin_o(f_fin), .busy_o(f_busy)
  );

  miriscv_int_controller #(.N_IRQ(32), .ARB_MODE(1), .MCAUSE_BASE(32'h8000_0010)) u_rr (
    .clk_i(clk), .rst_i(rst), .int_req_i(req), .mie_i(mie),
    .int_ack_i(ack), .int_rst_i(irst),
    .int_o(r_int), .mcause_o(r_mc), .int_fin_o(r_fin), .busy_o(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        ack;
    logic        irst;
    logic        exp_int;
    logic [31:0] exp_mc;
    logic [31:0] exp_fin;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    mie  = '1;
    ack  = 1'b0;
    irst = 1'b0;
    step();
    rst  = 1'b0;
  endtask

  logic [31:0] rr_mc[4];
  logic [31:0] rr_fin[4];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1; req = '0; mie = '1; ack = 1'b0; irst = 1'b0;

    // Fixed priority: lines 2, 3, 5 together, served 2, 3, 5.
    tbl[0]  = '{32'h2C, 1'b0, 1'b0, 1'b1, 32'h8000_0012, 32'h0,  1'b1};
    tbl[1]  = '{32'h2C, 1'b1, 1'b0, 1'b0, 32'h8000_0012, 32'h0,  1'b1};
    tbl[2]  = '{32'h2C, 1'b0, 1'b1, 1'b0, 32'h8000_0012, 32'h4,  1'b1};
    tbl[3]  = '{32'h28, 1'b0, 1'b0, 1'b0, 32'h8000_0012, 32'h0,  1'b0};
    tbl[4]  = '{32'h28, 1'b0, 1'b0, 1'b1, 32'h8000_0013, 32'h0,  1'b1};
    tbl[5]  = '{32'h28, 1'b1, 1'b0, 1'b0, 32'h8000_0013, 32'h0,  1'b1};
    tbl[6]  = '{32'h28, 1'b0, 1'b1, 1'b0, 32'h8000_0013, 32'h8,  1'b1};
    tbl[7]  = '{32'h20, 1'b0, 1'b0, 1'b0, 32'h8000_0013, 32'h0,  1'b0};
    tbl[8]  = '{32'h20, 1'b0, 1'b0, 1'b1, 32'h8000_0015, 32'h0,  1'b1};
    tbl[9]  = '{32'h20, 1'b1, 1'b0, 1'b0, 32'h8000_0015, 32'h0,  1'b1};
    tbl[10] = '{32'h20, 1'b0, 1'b1, 1'b0, 32'h8000_0015, 32'h20, 1'b1};
    tbl[11] = '{32'h00, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 32'h0,  1'b0};
    tbl[12] = '{32'h00, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 32'h0,  1'b0};

    rr_mc[0] = 32'h8000_0010; rr_fin[0] = 32'h0000_0001;
    rr_mc[1] = 32'h8000_0011; rr_fin[1] = 32'h0000_0002;
    rr_mc[2] = 32'h8000_002F; rr_fin[2] = 32'h8000_0000;
    rr_mc[3] = 32'h8000_0010; rr_fin[3] = 32'h0000_0001;

    // Reset state
    do_reset();
    chk("rst_int",    32'(f_int),  32'h0);
    chk("rst_fin",    f_fin,       32'h0);
    chk("rst_busy",   32'(f_busy), 32'h0);
    chk("rst_mcause", f_mc,        32'h8000_0010);

    // Single request on line 5
    req = 32'h20;
    step();
    chk("single_int",    32'(f_int), 32'h1);
    chk("single_mcause", f_mc,       32'h8000_0015);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("single_ack_int",  32'(f_int),  32'h0);
    chk("single_ack_busy", 32'(f_busy), 32'h1);
    for (int i = 0; i < 10; i++) step();
    chk("single_wait_fin", f_fin, 32'h0);
    irst = 1'b1;
    step();
    irst = 1'b0;
    chk("single_fin", f_fin, 32'h20);
    req = '0;
    step();
    chk("single_fin_gone", f_fin,        32'h0);
    chk("single_idle",     32'(f_busy),  32'h0);
    step();
    step();
    chk("single_stay_low", 32'(f_int), 32'h0);

    // Table-driven fixed-priority sequence
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req  = tbl[i].req;
      ack  = tbl[i].ack;
      irst = tbl[i].irst;
      step();
      chk($sformatf("tbl%0d_int", i),  32'(f_int),  32'(tbl[i].exp_int));
      chk($sformatf("tbl%0d_mc", i),   f_mc,        tbl[i].exp_mc);
      chk($sformatf("tbl%0d_fin", i),  f_fin,       tbl[i].exp_fin);
      chk($sformatf("tbl%0d_busy", i), 32'(f_busy), 32'(tbl[i].exp_busy));
    end
    ack = 1'b0; irst = 1'b0;

    // Masked request never raises int_o
    do_reset();
    mie = ~32'h8;
    req = 32'h8;
    step(); step(); step();
    chk("mask_int",  32'(f_int),  32'h0);
    chk("mask_busy", 32'(f_busy), 32'h0);
    // Enable, then cancel by masking in PENDING
    mie = '1;
    step();
    chk("unmask_int", 32'(f_int), 32'h1);
    chk("unmask_mc",  f_mc,       32'h8000_0013);
    mie = ~32'h8;
    step();
    chk("cancel_int",  32'(f_int),  32'h0);
    chk("cancel_busy", 32'(f_busy), 32'h0);
    chk("cancel_fin",  f_fin,       32'h0);
    step();
    chk("cancel_fin2", f_fin, 32'h0);
    chk("cancel_mc_hold", f_mc, 32'h8000_0013);
    // Ack in the same cycle as the mask drop wins
    mie = '1;
    step();
    chk("ackwin_pend", 32'(f_int), 32'h1);
    mie = ~32'h8;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ackwin_int",  32'(f_int),  32'h0);
    chk("ackwin_busy", 32'(f_busy), 32'h1);
    step();
    chk("ackwin_svc_hold", 32'(f_busy), 32'h1);
    irst = 1'b1;
    step();
    irst = 1'b0;
    chk("ackwin_fin", f_fin, 32'h8);
    req = '0; mie = '1;
    step();

    // No preemption; latched id fixed in PENDING
    do_reset();
    req = 32'h20;
    step();
    req = 32'h21;
    step();
    chk("pend_latch_mc", f_mc, 32'h8000_0015);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("svc_nopreempt_int", 32'(f_int), 32'h0);
    chk("svc_nopreempt_mc",  f_mc,       32'h8000_0015);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("svc_stray_ack", f_fin, 32'h0);
    irst = 1'b1;
    step();
    irst = 1'b0;
    chk("nopre_fin5", f_fin, 32'h20);
    req = 32'h01;
    step();
    chk("nopre_idle", 32'(f_busy), 32'h0);
    step();
    chk("nopre_int0", 32'(f_int), 32'h1);
    chk("nopre_mc0",  f_mc,       32'h8000_0010);

    // Stray int_rst_i / int_ack_i in IDLE
    do_reset();
    irst = 1'b1;
    step();
    irst = 1'b0;
    chk("stray_rst_busy", 32'(f_busy), 32'h0);
    chk("stray_rst_fin",  f_fin,       32'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("stray_ack_busy", 32'(f_busy), 32'h0);
    chk("stray_ack_int",  32'(f_int),  32'h0);

    // Round-robin: 0, 1, 31 held high; order 0, 1, 31, 0
    do_reset();
    req = 32'h8000_0003;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d_int", k), 32'(r_int), 32'h1);
      chk($sformatf("rr%0d_mc", k),  r_mc,       rr_mc[k]);
      ack = 1'b1;
      step();
      ack = 1'b0;
      irst = 1'b1;
      step();
      irst = 1'b0;
      chk($sformatf("rr%0d_fin", k), r_fin, rr_fin[k]);
      step();
      chk($sformatf("rr%0d_idle", k), 32'(r_busy), 32'h0);
    end

    // Reset in SERVICE clears rr_ptr
    do_reset();
    req = 32'h2;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    irst = 1'b1; step(); irst = 1'b0;
    chk("rrs_fin1", r_fin, 32'h2);
    req = 32'h4;
    step();
    step();
    chk("rrs_pend2", r_mc, 32'h8000_0012);
    ack = 1'b1; step(); ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsvc_int",  32'(r_int),  32'h0);
    chk("rsvc_fin",  r_fin,       32'h0);
    chk("rsvc_busy", 32'(r_busy), 32'h0);
    chk("rsvc_mc",   r_mc,        32'h8000_0010);
    req = 32'h8000_0001;
    step();
    chk("rsvc_rr_int", 32'(r_int), 32'h1);
    chk("rsvc_rr_mc",  r_mc,       32'h8000_0010);

    // Reset in the FINISH cycle: no further pulse, rr_ptr back to 0
    ack = 1'b1; step(); ack = 1'b0;
    irst = 1'b1; step(); irst = 1'b0;
    chk("rfin_pulse", r_fin, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rfin_int",  32'(r_int),  32'h0);
    chk("rfin_fin",  r_fin,       32'h0);
    chk("rfin_busy", 32'(r_busy), 32'h0);
    chk("rfin_mc",   r_mc,        32'h8000_0010);
    step();
    chk("rfin_rr_int", 32'(r_int), 32'h1);
    chk("rfin_rr_mc",  r_mc,       32'h8000_0010);

    // Reset asserted together with int_rst_i: FINISH never entered
    ack = 1'b1; step(); ack = 1'b0;
    irst = 1'b1; rst = 1'b1;
    step();
    irst = 1'b0; rst = 1'b0;
    chk("rabort_fin", r_fin, 32'h0);
    req = '0;
    step();
    chk("rabort_fin2", r_fin, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
